// File: rtl/mem_stage.sv
// Memory stage of the five-stage RISC-V pipeline: word loads/stores over a
// req/ack interface, pipeline stall while waiting, and the MEM/WB register.
module mem_stage #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ALU_OUT_ME,
    input  logic [31:0] WD_ME,
    input  logic [4:0]  RD_ME,
    input  logic        MEM_WE_ME,
    input  logic        MEM_TO_REG_ME,
    input  logic        WE_ME,
    input  logic        DMEM_ACK,
    input  logic [31:0] DMEM_RDATA,
    input  logic        ERR_CLR,
    output logic        DMEM_REQ,
    output logic [31:0] DMEM_ADDR,
    output logic [31:0] DMEM_WDATA,
    output logic        DMEM_WE,
    output logic        STALL_ME,
    output logic [31:0] BP_MEM,
    output logic [31:0] WB_DATA,
    output logic [4:0]  WB_RD,
    output logic        WB_WE,
    output logic        ERR_ME
);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;

    logic w_mem_op;
    logic w_mis;
    logic w_timeout;
    logic w_req;
    logic w_stall;
    logic w_retire;
    logic w_err_set;

    assign w_mem_op  = MEM_WE_ME | MEM_TO_REG_ME;
    assign w_mis     = w_mem_op & (ALU_OUT_ME[1:0] != 2'b00);
    assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == TO_VAL);

    // NOTE: non-blocking assignments for every flop so all state updates
    // see the pre-edge values, regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: w_next gets a default before the case so no latch is inferred.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_mem_op && !w_mis && !DMEM_ACK) w_next = S_WAIT;
            S_WAIT: if (DMEM_ACK || w_timeout) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // w_retire commits the current instruction to MEM/WB; otherwise a bubble.
    always_comb begin
        w_req     = 1'b0;
        w_stall   = 1'b0;
        w_retire  = 1'b0;
        w_err_set = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_mem_op) begin
                    w_retire = 1'b1;
                end else if (w_mis) begin
                    w_err_set = 1'b1;
                end else begin
                    w_req = 1'b1;
                    if (DMEM_ACK) w_retire = 1'b1;
                    else          w_stall  = 1'b1;
                end
            end
            S_WAIT: begin
                if (DMEM_ACK) begin
                    w_req    = 1'b1;
                    w_retire = 1'b1;
                end else if (w_timeout) begin
                    w_err_set = 1'b1;
                end else begin
                    w_req   = 1'b1;
                    w_stall = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Reset must drop the handshake immediately, even mid-WAIT.
    assign DMEM_REQ   = w_req & ~rst;
    assign STALL_ME   = w_stall & ~rst;
    assign DMEM_ADDR  = {ALU_OUT_ME[31:2], 2'b00};
    assign DMEM_WDATA = WD_ME;
    assign DMEM_WE    = MEM_WE_ME;
    assign BP_MEM     = ALU_OUT_ME;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_state == S_IDLE) begin
            r_cnt <= (w_next == S_WAIT) ? CNT_W'(1) : '0;
        end else if (w_next == S_IDLE) begin
            r_cnt <= '0;
        end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            WB_DATA <= '0;
            WB_RD   <= '0;
            WB_WE   <= 1'b0;
        end else begin
            WB_WE <= w_retire & WE_ME;
            if (w_retire) begin
                WB_DATA <= (w_mem_op && MEM_TO_REG_ME) ? DMEM_RDATA : ALU_OUT_ME;
                WB_RD   <= RD_ME;
            end
        end
    end

    // Set has priority over clear so a fault is never lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ERR_ME <= 1'b0;
        end else if (w_err_set) begin
            ERR_ME <= 1'b1;
        end else if (ERR_CLR) begin
            ERR_ME <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: each task drives one scenario and checks
// its outputs against hand-computed values.
module tb_mem_stage;

    logic        clk;
    logic        rst;
    logic [31:0] ALU_OUT_ME;
    logic [31:0] WD_ME;
    logic [4:0]  RD_ME;
    logic        MEM_WE_ME;
    logic        MEM_TO_REG_ME;
    logic        WE_ME;
    logic        DMEM_ACK;
    logic [31:0] DMEM_RDATA;
    logic        ERR_CLR;
    logic        DMEM_REQ;
    logic [31:0] DMEM_ADDR;
    logic [31:0] DMEM_WDATA;
    logic        DMEM_WE;
    logic        STALL_ME;
    logic [31:0] BP_MEM;
    logic [31:0] WB_DATA;
    logic [4:0]  WB_RD;
    logic        WB_WE;
    logic        ERR_ME;

    int errors = 0;
    int checks = 0;

    mem_stage #(.TIMEOUT_CYCLES(4), .CNT_W(5)) dut (
        .clk(clk), .rst(rst),
        .ALU_OUT_ME(ALU_OUT_ME), .WD_ME(WD_ME), .RD_ME(RD_ME),
        .MEM_WE_ME(MEM_WE_ME), .MEM_TO_REG_ME(MEM_TO_REG_ME), .WE_ME(WE_ME),
        .DMEM_ACK(DMEM_ACK), .DMEM_RDATA(DMEM_RDATA), .ERR_CLR(ERR_CLR),
        .DMEM_REQ(DMEM_REQ), .DMEM_ADDR(DMEM_ADDR), .DMEM_WDATA(DMEM_WDATA),
        .DMEM_WE(DMEM_WE), .STALL_ME(STALL_ME), .BP_MEM(BP_MEM),
        .WB_DATA(WB_DATA), .WB_RD(WB_RD), .WB_WE(WB_WE), .ERR_ME(ERR_ME)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; outputs are read there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] alu, input logic [31:0] wd,
                         input logic [4:0] rd, input logic mwe, input logic m2r,
                         input logic we, input logic ack, input logic [31:0] rdata);
        ALU_OUT_ME = alu; WD_ME = wd; RD_ME = rd; MEM_WE_ME = mwe;
        MEM_TO_REG_ME = m2r; WE_ME = we; DMEM_ACK = ack; DMEM_RDATA = rdata;
        ERR_CLR = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (WB_DATA !== 32'h0) begin errors++; $display("FAIL reset_wb_data: got %h want 0", WB_DATA); end
        checks++; if (WB_RD !== 5'd0) begin errors++; $display("FAIL reset_wb_rd: got %0d want 0", WB_RD); end
        checks++; if (WB_WE !== 1'b0) begin errors++; $display("FAIL reset_wb_we: got %b want 0", WB_WE); end
        checks++; if (ERR_ME !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", ERR_ME); end
        checks++; if (DMEM_REQ !== 1'b0 || STALL_ME !== 1'b0) begin errors++; $display("FAIL reset_req_stall: got %b%b want 00", DMEM_REQ, STALL_ME); end
        #10 rst = 1'b0;
        tick();
    endtask

    task automatic test_passthrough();
        drive(32'h0000_1234, 32'h0, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        #1;
        checks++; if (BP_MEM !== 32'h0000_1234) begin errors++; $display("FAIL pass_bp: got %h want 00001234", BP_MEM); end
        checks++; if (DMEM_REQ !== 1'b0 || STALL_ME !== 1'b0) begin errors++; $display("FAIL pass_req_stall: got %b%b want 00", DMEM_REQ, STALL_ME); end
        tick();
        checks++; if (WB_DATA !== 32'h0000_1234) begin errors++; $display("FAIL pass_wb_data: got %h want 00001234", WB_DATA); end
        checks++; if (WB_RD !== 5'd5) begin errors++; $display("FAIL pass_wb_rd: got %0d want 5", WB_RD); end
        checks++; if (WB_WE !== 1'b1) begin errors++; $display("FAIL pass_wb_we: got %b want 1", WB_WE); end
    endtask

    task automatic test_load_wait();
        drive(32'h0000_0100, 32'h0, 5'd7, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (STALL_ME !== 1'b1 || DMEM_REQ !== 1'b1) begin errors++; $display("FAIL load_wait_stall[%0d]: got stall=%b req=%b want 1 1", i, STALL_ME, DMEM_REQ); end
            checks++; if (DMEM_ADDR !== 32'h100 || DMEM_WE !== 1'b0) begin errors++; $display("FAIL load_wait_addr[%0d]: got %h we=%b want 00000100 we=0", i, DMEM_ADDR, DMEM_WE); end
            tick();
            checks++; if (WB_WE !== 1'b0) begin errors++; $display("FAIL load_wait_bubble[%0d]: got %b want 0", i, WB_WE); end
        end
        DMEM_ACK = 1'b1; DMEM_RDATA = 32'hDEAD_BEEF;
        #1;
        checks++; if (STALL_ME !== 1'b0 || DMEM_REQ !== 1'b1) begin errors++; $display("FAIL load_ack_cycle: got stall=%b req=%b want 0 1", STALL_ME, DMEM_REQ); end
        tick();
        checks++; if (WB_DATA !== 32'hDEAD_BEEF) begin errors++; $display("FAIL load_wb_data: got %h want deadbeef", WB_DATA); end
        checks++; if (WB_RD !== 5'd7 || WB_WE !== 1'b1) begin errors++; $display("FAIL load_wb_rd_we: got %0d %b want 7 1", WB_RD, WB_WE); end
    endtask

    task automatic test_store_zero_wait();
        drive(32'h0000_0200, 32'hCAFE_F00D, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h1357_9BDF);
        #1;
        checks++; if (DMEM_REQ !== 1'b1 || DMEM_WE !== 1'b1) begin errors++; $display("FAIL store_req_we: got %b%b want 11", DMEM_REQ, DMEM_WE); end
        checks++; if (DMEM_WDATA !== 32'hCAFE_F00D || DMEM_ADDR !== 32'h200) begin errors++; $display("FAIL store_data_addr: got %h %h want cafef00d 00000200", DMEM_WDATA, DMEM_ADDR); end
        checks++; if (STALL_ME !== 1'b0) begin errors++; $display("FAIL store_stall: got %b want 0", STALL_ME); end
        tick();
        checks++; if (WB_WE !== 1'b0) begin errors++; $display("FAIL store_wb_we: got %b want 0", WB_WE); end
        checks++; if (WB_DATA !== 32'h200) begin errors++; $display("FAIL store_wb_data: got %h want 00000200", WB_DATA); end
    endtask

    task automatic test_misaligned();
        drive(32'h0000_0102, 32'h0, 5'd9, 1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF);
        #1;
        checks++; if (DMEM_REQ !== 1'b0 || STALL_ME !== 1'b0) begin errors++; $display("FAIL mis_req_stall: got %b%b want 00", DMEM_REQ, STALL_ME); end
        checks++; if (DMEM_ADDR !== 32'h100) begin errors++; $display("FAIL mis_addr_mask: got %h want 00000100", DMEM_ADDR); end
        tick();
        checks++; if (ERR_ME !== 1'b1 || WB_WE !== 1'b0) begin errors++; $display("FAIL mis_err_bubble: got err=%b we=%b want 1 0", ERR_ME, WB_WE); end
        drive(32'h0000_0044, 32'h0, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        checks++; if (ERR_ME !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b want 1", ERR_ME); end
        ERR_CLR = 1'b1;
        tick();
        checks++; if (ERR_ME !== 1'b0) begin errors++; $display("FAIL err_clear: got %b want 0", ERR_ME); end
        drive(32'h0000_0301, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        ERR_CLR = 1'b1;
        tick();
        checks++; if (ERR_ME !== 1'b1) begin errors++; $display("FAIL err_set_wins: got %b want 1", ERR_ME); end
        drive(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        ERR_CLR = 1'b1;
        tick();
        ERR_CLR = 1'b0;
    endtask

    task automatic test_timeout();
        drive(32'h0000_0400, 32'h0, 5'd4, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (STALL_ME !== 1'b1 || DMEM_REQ !== 1'b1) begin errors++; $display("FAIL to_stall[%0d]: got stall=%b req=%b want 1 1", i, STALL_ME, DMEM_REQ); end
            tick();
        end
        #1;
        checks++; if (STALL_ME !== 1'b0 || DMEM_REQ !== 1'b0) begin errors++; $display("FAIL to_abort: got stall=%b req=%b want 0 0", STALL_ME, DMEM_REQ); end
        tick();
        checks++; if (ERR_ME !== 1'b1 || WB_WE !== 1'b0) begin errors++; $display("FAIL to_err_bubble: got err=%b we=%b want 1 0", ERR_ME, WB_WE); end
        drive(32'h0000_0404, 32'h0, 5'd3, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0055);
        ERR_CLR = 1'b1;
        #1;
        checks++; if (STALL_ME !== 1'b0 || DMEM_REQ !== 1'b1) begin errors++; $display("FAIL to_next_op: got stall=%b req=%b want 0 1", STALL_ME, DMEM_REQ); end
        tick();
        checks++; if (WB_DATA !== 32'h55 || WB_RD !== 5'd3 || WB_WE !== 1'b1) begin errors++; $display("FAIL to_next_wb: got %h %0d %b want 00000055 3 1", WB_DATA, WB_RD, WB_WE); end
        checks++; if (ERR_ME !== 1'b0) begin errors++; $display("FAIL to_err_clear: got %b want 0", ERR_ME); end
    endtask

    task automatic test_back_to_back();
        drive(32'h0000_0010, 32'h0, 5'd1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h1111_1111);
        tick();
        checks++; if (WB_DATA !== 32'h1111_1111 || WB_RD !== 5'd1 || WB_WE !== 1'b1) begin errors++; $display("FAIL b2b_first: got %h %0d %b want 11111111 1 1", WB_DATA, WB_RD, WB_WE); end
        drive(32'h0000_0014, 32'h0, 5'd2, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        #1;
        checks++; if (STALL_ME !== 1'b1 || DMEM_REQ !== 1'b1) begin errors++; $display("FAIL b2b_second_req: got stall=%b req=%b want 1 1", STALL_ME, DMEM_REQ); end
        tick();
        DMEM_ACK = 1'b1; DMEM_RDATA = 32'h2222_2222;
        tick();
        checks++; if (WB_DATA !== 32'h2222_2222 || WB_RD !== 5'd2 || WB_WE !== 1'b1) begin errors++; $display("FAIL b2b_second: got %h %0d %b want 22222222 2 1", WB_DATA, WB_RD, WB_WE); end
    endtask

    task automatic test_reset_mid_wait();
        // Leave a fault flagged so the reset has something to clear.
        drive(32'h0000_0002, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        drive(32'h0000_0300, 32'h0, 5'd6, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        tick();
        checks++; if (STALL_ME !== 1'b1 || DMEM_REQ !== 1'b1 || ERR_ME !== 1'b1) begin errors++; $display("FAIL rst_pre_wait: got stall=%b req=%b err=%b want 1 1 1", STALL_ME, DMEM_REQ, ERR_ME); end
        #2 rst = 1'b1;
        #1;
        checks++; if (STALL_ME !== 1'b0 || DMEM_REQ !== 1'b0) begin errors++; $display("FAIL rst_mid_wait_drop: got stall=%b req=%b want 0 0", STALL_ME, DMEM_REQ); end
        checks++; if (WB_WE !== 1'b0 || ERR_ME !== 1'b0) begin errors++; $display("FAIL rst_mid_wait_regs: got we=%b err=%b want 0 0", WB_WE, ERR_ME); end
        drive(32'h0000_0ABC, 32'h0, 5'd8, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        #1 rst = 1'b0;
        #1;
        checks++; if (DMEM_REQ !== 1'b0 || STALL_ME !== 1'b0) begin errors++; $display("FAIL rst_release_idle: got req=%b stall=%b want 0 0", DMEM_REQ, STALL_ME); end
        tick();
        checks++; if (WB_DATA !== 32'h0ABC || WB_RD !== 5'd8 || WB_WE !== 1'b1) begin errors++; $display("FAIL rst_release_retire: got %h %0d %b want 00000abc 8 1", WB_DATA, WB_RD, WB_WE); end
    endtask

    initial begin
        rst = 1'b1;
        drive(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        test_reset();
        test_passthrough();
        test_load_wait();
        test_store_zero_wait();
        test_misaligned();
        test_timeout();
        test_back_to_back();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
